// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multi-cycle LEGv8 core with exceptions, ERET and MRS
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op,
  input  logic        zero,
  input  logic        extirq,
  output logic [3:0]  state,
  output logic [1:0]  aluop,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic        pcwrite,
  output logic        irwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        reg2loc,
  output logic        mrs,
  output logic        exc,
  output logic [1:0]  exc_code
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_CBZ    = 4'd8,
    S_BRANCH = 4'd9,
    S_ERET   = 4'd10,
    S_MRS    = 4'd11,
    S_EXC    = 4'd12
  } state_t;
  state_t     state_q, state_d;
  logic [1:0] exc_code_q, exc_code_d;
  logic is_ldur, is_stur, is_rtype, is_cbz, is_b, is_eret, is_mrs;
  assign is_ldur  = op == 11'b11111000010;
  assign is_stur  = op == 11'b11111000000;
  assign is_rtype = op == 11'b10001011000 || op == 11'b11001011000 ||
                    op == 11'b10001010000 || op == 11'b10101010000;
  assign is_cbz   = op[10:3] == 8'b10110100;
  assign is_b     = op[10:5] == 6'b000101;
  assign is_eret  = op == 11'b11010110100;
  assign is_mrs   = op == 11'b11010101001;
  assign state    = reset ? state_q : 4'd0;
  assign exc_code = exc_code_q;
  // State and exception-cause registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      exc_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      exc_code_q <= exc_code_d;
    end
  end
  // Next state; the cause is captured only on the DECODE to EXC transition
  always_comb begin
    state_d    = S_FETCH;
    exc_code_d = exc_code_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (extirq) begin
          state_d    = S_EXC;
          exc_code_d = 2'b01;
        end else if (is_ldur || is_stur) state_d = S_MEMADR;
        else if (is_rtype) state_d = S_EXEC;
        else if (is_cbz)   state_d = S_CBZ;
        else if (is_b)     state_d = S_BRANCH;
        else if (is_eret)  state_d = S_ERET;
        else if (is_mrs)   state_d = S_MRS;
        else begin
          state_d    = S_EXC;
          exc_code_d = 2'b10;
        end
      end
      S_MEMADR: state_d = is_ldur ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end
  // Moore output decode (CBZ pcwrite follows zero); everything is held low during reset
  always_comb begin
    aluop    = 2'b00;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    reg2loc  = 1'b0;
    mrs      = 1'b0;
    exc      = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        reg2loc = is_stur || is_cbz;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:  memread = 1'b1;
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        reg2loc  = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB:  regwrite = 1'b1;
      S_CBZ: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        reg2loc = 1'b1;
        pcsrc   = 2'b01;
        pcwrite = zero;
      end
      S_BRANCH: begin
        pcsrc   = 2'b01;
        pcwrite = 1'b1;
      end
      S_ERET: begin
        aluop   = 2'b01;
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      S_MRS: begin
        aluop    = 2'b01;
        regwrite = 1'b1;
        mrs      = 1'b1;
      end
      S_EXC: begin
        exc     = 1'b1;
        pcsrc   = 2'b11;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      aluop    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      memtoreg = 1'b0;
      reg2loc  = 1'b0;
      mrs      = 1'b0;
      exc      = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven per-cycle check of the multi-cycle control FSM
module tb_multicycle_ctrl;
  logic        clk = 1'b0, reset = 1'b0, zero = 1'b0, extirq = 1'b0;
  logic [10:0] op = '0;
  logic [3:0]  state;
  logic [1:0]  aluop, alusrcb, pcsrc, exc_code;
  logic        alusrca, pcwrite, irwrite, memread, memwrite, regwrite, memtoreg, reg2loc, mrs, exc;
  int passed = 0, total = 0;
  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000, ORR = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000, CBZ = 11'b10110100101;
  localparam logic [10:0] BR = 11'b00010111111, ERET = 11'b11010110100, MRS = 11'b11010101001;
  localparam logic [10:0] BAD = 11'b00000000000;
  typedef struct {
    logic [10:0] op;
    logic        zero, irq;
    logic [3:0]  st;
    logic [1:0]  aluop;
    logic        srca;
    logic [1:0]  srcb, pcsrc;
    logic [8:0]  stb;
    logic [1:0]  code;
  } vec_t;
  vec_t tbl[$];
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .extirq(extirq), .state(state),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcwrite(pcwrite),
    .irwrite(irwrite), .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .memtoreg(memtoreg), .reg2loc(reg2loc), .mrs(mrs), .exc(exc), .exc_code(exc_code)
  );
  always #5 clk = ~clk;
  function automatic logic [21:0] act();
    return {state, aluop, alusrca, alusrcb, pcsrc, pcwrite, irwrite, memread, memwrite,
            regwrite, memtoreg, reg2loc, mrs, exc, exc_code};
  endfunction
  task automatic chk(input string name, input logic [21:0] a, input logic [21:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", name, a, e);
    else passed++;
  endtask
  task automatic add(input logic [10:0] o, input logic z, input logic i, input logic [3:0] st,
                     input logic [1:0] al, input logic sa, input logic [1:0] sb,
                     input logic [1:0] ps, input logic [8:0] stb, input logic [1:0] code);
    vec_t v;
    v.op = o; v.zero = z; v.irq = i; v.st = st; v.aluop = al; v.srca = sa;
    v.srcb = sb; v.pcsrc = ps; v.stb = stb; v.code = code;
    tbl.push_back(v);
  endtask
  // strobe order: pcwrite irwrite memread memwrite regwrite memtoreg reg2loc mrs exc
  initial begin
    add(ADD, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(ADD, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b00);
    add(ADD, 0, 0, 6, 2'b10, 1, 2'b00, 2'b00, 9'b000000000, 2'b00);
    add(ADD, 0, 0, 7, 2'b00, 0, 2'b00, 2'b00, 9'b000010000, 2'b00);
    add(ORR, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(ORR, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b00);
    add(ORR, 0, 0, 6, 2'b10, 1, 2'b00, 2'b00, 9'b000000000, 2'b00);
    add(ORR, 0, 0, 7, 2'b00, 0, 2'b00, 2'b00, 9'b000010000, 2'b00);
    add(LDUR, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(LDUR, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b00);
    add(LDUR, 0, 0, 2, 2'b00, 1, 2'b10, 2'b00, 9'b000000000, 2'b00);
    add(LDUR, 0, 0, 3, 2'b00, 0, 2'b00, 2'b00, 9'b001000000, 2'b00);
    add(LDUR, 0, 0, 4, 2'b00, 0, 2'b00, 2'b00, 9'b000011000, 2'b00);
    add(STUR, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(STUR, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000100, 2'b00);
    add(STUR, 0, 0, 2, 2'b00, 1, 2'b10, 2'b00, 9'b000000000, 2'b00);
    add(STUR, 0, 0, 5, 2'b00, 0, 2'b00, 2'b00, 9'b000100100, 2'b00);
    add(CBZ, 1, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(CBZ, 1, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000100, 2'b00);
    add(CBZ, 1, 0, 8, 2'b01, 1, 2'b00, 2'b01, 9'b100000100, 2'b00);
    add(CBZ, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(CBZ, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000100, 2'b00);
    add(CBZ, 0, 0, 8, 2'b01, 1, 2'b00, 2'b01, 9'b000000100, 2'b00);
    add(BR, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(BR, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b00);
    add(BR, 0, 0, 9, 2'b00, 0, 2'b00, 2'b01, 9'b100000000, 2'b00);
    add(BAD, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b00);
    add(BAD, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b00);
    add(BAD, 0, 0, 12, 2'b00, 0, 2'b00, 2'b11, 9'b100000001, 2'b10);
    add(MRS, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b10);
    add(MRS, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b10);
    add(MRS, 0, 0, 11, 2'b01, 0, 2'b00, 2'b00, 9'b000010010, 2'b10);
    add(ERET, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b10);
    add(ERET, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b10);
    add(ERET, 0, 0, 10, 2'b01, 0, 2'b00, 2'b10, 9'b100000000, 2'b10);
    add(BAD, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b10);
    add(BAD, 0, 1, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b10);
    add(BAD, 0, 0, 12, 2'b00, 0, 2'b00, 2'b11, 9'b100000001, 2'b01);
    add(ADD, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b01);
    add(ADD, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b01);
    add(ADD, 0, 1, 6, 2'b10, 1, 2'b00, 2'b00, 9'b000000000, 2'b01);
    add(ADD, 0, 0, 7, 2'b00, 0, 2'b00, 2'b00, 9'b000010000, 2'b01);
    add(SUB, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 9'b111000000, 2'b01);
    add(SUB, 0, 0, 1, 2'b00, 0, 2'b11, 2'b00, 9'b000000000, 2'b01);
    add(SUB, 0, 0, 6, 2'b10, 1, 2'b00, 2'b00, 9'b000000000, 2'b01);
    add(SUB, 0, 0, 7, 2'b00, 0, 2'b00, 2'b00, 9'b000010000, 2'b01);
    op = ADD;
    repeat (2) @(negedge clk);
    #1 chk("reset_idle", act(), 22'd0);
    @(negedge clk);
    reset = 1'b1;
    foreach (tbl[k]) begin
      op = tbl[k].op;
      zero = tbl[k].zero;
      extirq = tbl[k].irq;
      #1 chk($sformatf("vec%0d_st%0d", k, tbl[k].st), act(),
             {tbl[k].st, tbl[k].aluop, tbl[k].srca, tbl[k].srcb, tbl[k].pcsrc, tbl[k].stb, tbl[k].code});
      @(negedge clk);
    end
    op = ADD;
    zero = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("pre_reset_exec", act(), {4'd6, 2'b10, 1'b1, 2'b00, 2'b00, 9'b000000000, 2'b01});
    reset = 1'b0;
    #1 chk("reset_mid_exec", act(), 22'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk($sformatf("reset_hold%0d", c), act(), 22'd0);
    end
    reset = 1'b1;
    #1 chk("release_fetch", act(), {4'd0, 2'b00, 1'b0, 2'b01, 2'b00, 9'b111000000, 2'b00});
    @(negedge clk);
    #1 chk("first_decode", act(), {4'd1, 2'b00, 1'b0, 2'b11, 2'b00, 9'b000000000, 2'b00});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
